fwd_sel_pipe: RTL and testbench

Parametrised forwarding selector with an output pipeline register for the pipelined MIPS datapath. Each cycle it picks one operand value from the register-file read data or one of NSRC forwarding sources (EX/MEM, MEM/WR, …), using a fixed priority and destination-address matching. It raises a stall request when the winning source's value is not yet available. The chosen value is registered into the next pipeline stage, with stall, flush and a saturating stall counter. One instance sits per operand (rs, rt) at the ID/EX boundary.

---
 rtl/fwd_sel_pipe.sv | 117 +++++++++++
 tb/tb_fwd_sel_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_sel_pipe.sv
// Operand forwarding selector for the ID/EX boundary: it picks rf_data or a
// forwarding source by fixed priority, raises a load-use stall, and registers the result.
module fwd_sel_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 3,
    parameter int unsigned AW    = 5,
    parameter int unsigned SW    = $clog2(NSRC + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic                    en,
    input  logic                    flush,
    input  logic [AW-1:0]           rd_addr,
    input  logic [WIDTH-1:0]        rf_data,
    input  logic [NSRC-1:0]         src_wen,
    input  logic [NSRC*AW-1:0]      src_addr,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    input  logic [NSRC-1:0]         src_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SW-1:0]           out_sel,
    output logic                    stall_req,
    output logic [15:0]             stall_cnt
);

    localparam int unsigned CW = 16;

    logic [NSRC-1:0]  w_match;
    logic             w_hit;
    logic             w_win_ready;
    logic [WIDTH-1:0] w_win_data;
    logic [SW-1:0]    w_win_sel;
    logic [WIDTH-1:0] w_sel_data;
    logic [SW-1:0]    w_sel_code;

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SW-1:0]    r_out_sel;
    logic [CW-1:0]    r_stall_cnt;

    // Destination-address match per source; r0 and bubbles never match
    always_comb begin
        w_match = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            w_match[i] = src_wen[i] & (src_addr[i*AW +: AW] == rd_addr)
                         & (rd_addr != '0) & in_valid;
        end
    end

    // Scan from lowest priority upward so the lowest matching index wins
    always_comb begin
        w_hit       = 1'b0;
        w_win_ready = 1'b0;
        w_win_data  = '0;
        w_win_sel   = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit       = 1'b1;
                w_win_ready = src_ready[i];
                w_win_data  = src_data[i*WIDTH +: WIDTH];
                w_win_sel   = SW'(i + 1);
            end
        end
    end

    always_comb begin
        w_sel_data = rf_data;
        w_sel_code = '0;
        if (rd_addr == '0) begin
            w_sel_data = '0;
        end else if (w_hit) begin
            w_sel_data = w_win_data;
            w_sel_code = w_win_sel;
        end
    end

    assign stall_req = w_hit & ~w_win_ready;

    // Output stage: flush > external hold > hazard bubble > load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
        end else if (flush) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
        end else if (!en) begin
            r_out_data  <= r_out_data;
            r_out_valid <= r_out_valid;
            r_out_sel   <= r_out_sel;
        end else if (stall_req) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_data  <= w_sel_data;
            r_out_valid <= in_valid;
            r_out_sel   <= w_sel_code;
        end
    end

    // Stall cycles counted regardless of en, saturating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (stall_req && !flush && (r_stall_cnt != {CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_sel_pipe.sv
// Directed self-checking bench for fwd_sel_pipe using immediate assertions.
module tb_fwd_sel_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NSRC  = 3;
    localparam int unsigned AW    = 5;
    localparam int unsigned SW    = $clog2(NSRC + 1);

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  in_valid;
    logic                  en;
    logic                  flush;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rf_data;
    logic [NSRC-1:0]       src_wen;
    logic [NSRC*AW-1:0]    src_addr;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       src_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic [SW-1:0]         out_sel;
    logic                  stall_req;
    logic [15:0]           stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    fwd_sel_pipe #(.WIDTH(WIDTH), .NSRC(NSRC), .AW(AW), .SW(SW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .en        (en),
        .flush     (flush),
        .rd_addr   (rd_addr),
        .rf_data   (rf_data),
        .src_wen   (src_wen),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .src_ready (src_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .stall_req (stall_req),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        src_addr[i*AW +: AW]       = a;
        src_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic chk_out(input string tag, input logic [WIDTH-1:0] d, input logic v,
                           input logic [SW-1:0] s);
        chk({tag, ".data"},  64'(out_data),  64'(d));
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".sel"},   64'(out_sel),   64'(s));
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        en        = 1'b1;
        flush     = 1'b0;
        rd_addr   = '0;
        rf_data   = '0;
        src_wen   = '0;
        src_addr  = '0;
        src_data  = '0;
        src_ready = '0;
        #12;
        chk_out("reset", 32'h0, 1'b0, 2'd0);
        chk("reset.cnt", 64'(stall_cnt), 64'd0);
        reset_n = 1'b1;

        // Priority: sources 0 and 2 both write r5
        in_valid  = 1'b1;
        rd_addr   = 5'd5;
        rf_data   = 32'h0BAD0BAD;
        set_src(0, 5'd5, 32'hAAAA0000);
        set_src(1, 5'd7, 32'hBBBB0000);
        set_src(2, 5'd5, 32'hCCCC0000);
        src_wen   = 3'b101;
        src_ready = 3'b111;
        #1;
        chk("prio.stall", 64'(stall_req), 64'd0);
        step();
        chk_out("prio", 32'hAAAA0000, 1'b1, 2'd1);

        // Only source 2 matches
        src_wen = 3'b100;
        step();
        chk_out("src2", 32'hCCCC0000, 1'b1, 2'd3);

        // No match: register file
        src_wen = 3'b000;
        rf_data = 32'h11112222;
        step();
        chk_out("rf", 32'h11112222, 1'b1, 2'd0);

        // Load-use: source 0 unready for two cycles
        rd_addr   = 5'd8;
        set_src(0, 5'd8, 32'h00001234);
        src_wen   = 3'b001;
        src_ready = 3'b110;
        #1;
        chk("lu.stall", 64'(stall_req), 64'd1);
        step();
        chk_out("lu1", 32'h11112222, 1'b0, 2'd0);
        step();
        chk_out("lu2", 32'h11112222, 1'b0, 2'd0);
        chk("lu2.cnt", 64'(stall_cnt), 64'd2);
        src_ready = 3'b111;
        #1;
        chk("lu.release", 64'(stall_req), 64'd0);
        step();
        chk_out("lu3", 32'h00001234, 1'b1, 2'd1);
        chk("lu3.cnt", 64'(stall_cnt), 64'd2);

        // Unready higher-priority match is not overridden by a ready lower one
        set_src(1, 5'd8, 32'h00005678);
        src_wen   = 3'b011;
        src_ready = 3'b110;
        #1;
        chk("shadow.stall", 64'(stall_req), 64'd1);
        step();
        chk("shadow.valid", 64'(out_valid), 64'd0);
        chk("shadow.cnt", 64'(stall_cnt), 64'd3);

        // Flush during stall: outputs cleared, counter frozen
        flush = 1'b1;
        #1;
        chk("flush.stall", 64'(stall_req), 64'd1);
        step();
        chk_out("flush", 32'h0, 1'b0, 2'd0);
        chk("flush.cnt", 64'(stall_cnt), 64'd3);
        flush = 1'b0;

        // Load r9 from the register file
        src_wen   = 3'b000;
        src_ready = 3'b111;
        rd_addr   = 5'd9;
        rf_data   = 32'h00000055;
        step();
        chk_out("load55", 32'h00000055, 1'b1, 2'd0);

        // Hold with en=0 while rf_data changes
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rf_data = 32'h00000060 + 32'(k);
            step();
            chk_out("hold", 32'h00000055, 1'b1, 2'd0);
        end
        // en=0 during a stall: out_valid held, counter still counts
        set_src(0, 5'd9, 32'h0000FFFF);
        src_wen   = 3'b001;
        src_ready = 3'b110;
        step();
        chk_out("holdstall", 32'h00000055, 1'b1, 2'd0);
        chk("holdstall.cnt", 64'(stall_cnt), 64'd4);
        src_wen   = 3'b000;
        src_ready = 3'b111;
        en        = 1'b1;
        rf_data   = 32'h00000077;
        step();
        chk_out("resume", 32'h00000077, 1'b1, 2'd0);

        // in_valid=0 suppresses matching
        in_valid  = 1'b0;
        rf_data   = 32'h00000099;
        src_wen   = 3'b001;
        src_ready = 3'b110;
        #1;
        chk("nv.stall", 64'(stall_req), 64'd0);
        step();
        chk_out("nv", 32'h00000099, 1'b0, 2'd0);

        // Zero register with a matching r0 writer
        in_valid  = 1'b1;
        rd_addr   = 5'd0;
        rf_data   = 32'hDEADBEEF;
        set_src(0, 5'd0, 32'h12345678);
        src_wen   = 3'b001;
        src_ready = 3'b111;
        #1;
        chk("r0.stall", 64'(stall_req), 64'd0);
        step();
        chk_out("r0", 32'h0, 1'b1, 2'd0);

        // Async reset mid-stall
        rd_addr   = 5'd9;
        rf_data   = 32'h000000AB;
        step();
        set_src(0, 5'd9, 32'h0000EEEE);
        src_ready = 3'b110;
        step();
        chk("pre_rst.cnt", 64'(stall_cnt), 64'd5);
        chk("pre_rst.data", 64'(out_data), 64'h000000AB);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("arst", 32'h0, 1'b0, 2'd0);
        chk("arst.cnt", 64'(stall_cnt), 64'd0);
        reset_n   = 1'b1;
        src_wen   = 3'b000;
        src_ready = 3'b111;
        rd_addr   = 5'd10;
        rf_data   = 32'h00000ABC;
        step();
        chk_out("post_rst", 32'h00000ABC, 1'b1, 2'd0);
        chk("post_rst.cnt", 64'(stall_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
